// File: rtl/kara_overlap_accum_if.sv
// Term/product stream bundle for the Karatsuba overlap-accumulate stage.
// The master side offers partial products and consumes the recombined result.
interface kara_overlap_accum_if #(
  parameter int H = 12
);
  localparam int TW = 2*H - 1;
  localparam int OW = 4*H - 1;

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_tag;
  logic [TW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          tag_err;

  modport master (
    output in_valid, in_tag, in_data, out_ready,
    input  in_ready, out_valid, out_data, tag_err
  );

  modport slave (
    input  in_valid, in_tag, in_data, out_ready,
    output in_ready, out_valid, out_data, tag_err
  );
endinterface

// File: rtl/kara_overlap_accum.sv
// GF(2) Karatsuba overlap-accumulate: XORs low/mid/high terms at offsets 0/H/2H.
// Optional macro KARA_MIDFIX_EN: also folds low and high terms in at offset H.
module kara_overlap_accum #(
  parameter int H = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  kara_overlap_accum_if.slave bus
);
  localparam int TW = 2*H - 1;
  localparam int OW = 4*H - 1;

  logic [OW-1:0] acc_reg, acc_next;
  logic [2:0]    seen_reg, seen_next;
  logic          out_valid_reg, out_valid_next;
  logic          tag_err_reg, tag_err_next;

  logic [OW-1:0] term_at [3];
  logic [OW-1:0] contrib;
  logic [2:0]    tag_onehot;
  logic          xfer;
  logic          tag_legal;

  // The high term lands on bits 2H..OW-1, so no shifted bit is ever lost.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_offset
      assign term_at[gi] = {{(OW-TW){1'b0}}, bus.in_data} << (gi*H);
    end
  endgenerate

  assign bus.in_ready  = !out_valid_reg && !clr;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = acc_reg;
  assign bus.tag_err   = tag_err_reg;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign tag_legal = |(tag_onehot & ~seen_reg);

  always_comb begin
    tag_onehot = 3'b000;
    contrib    = '0;
    case (bus.in_tag)
      2'd0: begin
        tag_onehot = 3'b001;
`ifdef KARA_MIDFIX_EN
        contrib    = term_at[0] ^ term_at[1];
`else
        contrib    = term_at[0];
`endif
      end
      2'd1: begin
        tag_onehot = 3'b010;
        contrib    = term_at[1];
      end
      2'd2: begin
        tag_onehot = 3'b100;
`ifdef KARA_MIDFIX_EN
        contrib    = term_at[2] ^ term_at[1];
`else
        contrib    = term_at[2];
`endif
      end
      default: begin
        tag_onehot = 3'b000;
        contrib    = '0;
      end
    endcase
  end

  always_comb begin
    acc_next       = acc_reg;
    seen_next      = seen_reg;
    out_valid_next = out_valid_reg;
    tag_err_next   = xfer && !tag_legal;
    if (clr) begin
      acc_next       = '0;
      seen_next      = 3'b000;
      out_valid_next = 1'b0;
      tag_err_next   = 1'b0;
    end else if (out_valid_reg) begin
      if (bus.out_ready) begin
        acc_next       = '0;
        seen_next      = 3'b000;
        out_valid_next = 1'b0;
      end
    end else if (xfer && tag_legal) begin
      acc_next       = acc_reg ^ contrib;
      seen_next      = seen_reg | tag_onehot;
      out_valid_next = (seen_next == 3'b111);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg       <= '0;
      seen_reg      <= 3'b000;
      out_valid_reg <= 1'b0;
      tag_err_reg   <= 1'b0;
    end else begin
      acc_reg       <= acc_next;
      seen_reg      <= seen_next;
      out_valid_reg <= out_valid_next;
      tag_err_reg   <= tag_err_next;
    end
  end
endmodule

// File: tb/tb_kara_overlap_accum.sv
// Directed bench for kara_overlap_accum: term-level model plus literal result checks.
// Build with +define+KARA_MIDFIX_EN to check the corrected-middle variant.
module tb_kara_overlap_accum;
  localparam int H  = 12;
  localparam int TW = 2*H - 1;
  localparam int OW = 4*H - 1;

`ifdef KARA_MIDFIX_EN
  localparam logic [OW-1:0] EXP_ORDER = 47'h0000007FFFFF;
  localparam logic [OW-1:0] EXP_FRESH = 47'h400400BBCABC;
  localparam logic [OW-1:0] EXP_LOW1  = 47'h000000001001;
`else
  localparam logic [OW-1:0] EXP_ORDER = 47'h0007FF800FFF;
  localparam logic [OW-1:0] EXP_FRESH = 47'h400000100ABC;
  localparam logic [OW-1:0] EXP_LOW1  = 47'h000000000001;
`endif
  localparam logic [OW-1:0] EXP_ONES = 47'h000001001001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;
  always #5 clk = ~clk;

  kara_overlap_accum_if #(.H(H)) bus ();
  kara_overlap_accum #(.H(H)) dut (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus));

  int checks     = 0;
  int failures   = 0;
  int err_pulses = 0;

  // Model: which terms have been accepted and their values; result is the XOR fold.
  logic [TW-1:0] m_term [3];
  logic [2:0]    m_seen;
  logic          m_valid;
  logic          m_err;

  function automatic logic [OW-1:0] model_product(input logic [2:0] seen,
                                                  input logic [TW-1:0] t0,
                                                  input logic [TW-1:0] t1,
                                                  input logic [TW-1:0] t2);
    logic [OW-1:0] r;
    logic [OW-1:0] v [3];
    r = '0;
    v[0] = OW'(t0);
    v[1] = OW'(t1);
    v[2] = OW'(t2);
    for (int t = 0; t < 3; t++) begin
      if (seen[t]) begin
        r = r ^ (v[t] << (t*H));
`ifdef KARA_MIDFIX_EN
        if (t != 1) r = r ^ (v[t] << H);
`endif
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_seen  <= 3'b000;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
    end else if (clr) begin
      m_seen  <= 3'b000;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (m_valid) begin
        if (bus.out_ready) begin
          m_seen  <= 3'b000;
          m_valid <= 1'b0;
        end
      end else if (bus.in_valid) begin
        if (bus.in_tag == 2'd3 || m_seen[bus.in_tag]) begin
          m_err <= 1'b1;
        end else begin
          m_term[bus.in_tag] <= bus.in_data;
          m_seen[bus.in_tag] <= 1'b1;
          if ((m_seen | (3'b001 << bus.in_tag)) == 3'b111) m_valid <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("model_in_ready",  OW'(bus.in_ready),  OW'(!m_valid && !clr));
        check("model_out_valid", OW'(bus.out_valid), OW'(m_valid));
        check("model_tag_err",   OW'(bus.tag_err),   OW'(m_err));
        check("model_out_data",  bus.out_data, model_product(m_seen, m_term[0], m_term[1], m_term[2]));
        if (bus.tag_err) err_pulses++;
      end
    end
  end

  task automatic send(input logic [1:0] t, input logic [TW-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_tag   = t;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    $display("term tag=%0d data=%h", t, d);
  endtask

  task automatic wait_result(input string name, input logic [OW-1:0] exp);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, OW'(n), OW'(0));
    check(name, bus.out_data, exp);
    $display("result %s data=%h", name, bus.out_data);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("handshake_drop", OW'(bus.out_valid), OW'(0));
  endtask

  initial begin
    int pulses0;
    bus.in_valid  = 1'b0;
    bus.in_tag    = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", OW'(bus.out_valid), OW'(0));
    check("rst_in_ready",  OW'(bus.in_ready),  OW'(1));
    check("rst_out_data",  bus.out_data,       47'h0);
    check("rst_tag_err",   OW'(bus.tag_err),   OW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Unit terms in natural order.
    send(2'd0, 23'h000001);
    send(2'd1, 23'h000001);
    send(2'd2, 23'h000001);
    wait_result("ones", EXP_ONES);
    take();

    // Reverse order, overlapping bits cancel.
    send(2'd2, 23'h000000);
    send(2'd1, 23'h7FFFFF);
    send(2'd0, 23'h7FFFFF);
    wait_result("order", EXP_ORDER);
    take();

    // Duplicate and illegal tags, then a long stall with a term offered in HOLD.
    pulses0 = err_pulses;
    send(2'd0, 23'h000001);
    send(2'd0, 23'h000001);
    send(2'd3, 23'h000001);
    send(2'd1, 23'h000001);
    send(2'd2, 23'h000001);
    wait_result("dup", EXP_ONES);
    bus.in_valid = 1'b1;
    bus.in_tag   = 2'd0;
    bus.in_data  = 23'h000005;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_data",     bus.out_data,       EXP_ONES);
      check("hold_in_ready", OW'(bus.in_ready),  OW'(0));
    end
    check("dup_err_pulses", OW'(err_pulses - pulses0), OW'(2));
    take();
    bus.in_valid = 1'b0;

    // Abort on the cycle the third term is offered.
    send(2'd0, 23'h000003);
    send(2'd1, 23'h000005);
    bus.in_valid = 1'b1;
    bus.in_tag   = 2'd2;
    bus.in_data  = 23'h000007;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("clr_no_valid", OW'(bus.out_valid), OW'(0));
      @(posedge clk); #1;
    end
    check("clr_acc", bus.out_data, 47'h0);
    send(2'd0, 23'h000ABC);
    send(2'd1, 23'h000100);
    send(2'd2, 23'h400000);
    wait_result("fresh", EXP_FRESH);
    take();

    // Only the low term is nonzero: shows whether the middle correction is applied.
    send(2'd0, 23'h000001);
    send(2'd1, 23'h000000);
    send(2'd2, 23'h000000);
    wait_result("low_only", EXP_LOW1);
    take();

    // Asynchronous reset mid-collection.
    send(2'd0, 23'h00FFFF);
    send(2'd2, 23'h000011);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data",  bus.out_data,      47'h0);
    check("async_rst_ready", OW'(bus.in_ready), OW'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(2'd1, 23'h000001);
    send(2'd0, 23'h000001);
    send(2'd2, 23'h000001);
    wait_result("after_rst", EXP_ONES);
    take();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/kara_overlap_accum.md
# kara_overlap_accum

Sequential, parametrised overlap-accumulate stage for the GF(2) Karatsuba multiplier chain. Accepts the three partial products of one Karatsuba level (low, middle, high) one term per cycle over a valid/ready stream, in any order, XOR-accumulates each term at its operand offset, and presents the recombined `4H-1`-bit product on a valid/ready output. It sits between the sub-multiplier pool and the next-level recombination, so a single sub-multiplier can be time-shared across the three terms.

## Interface
- `H`, 12, half-operand width; term width `TW = 2H-1`, result width `OW = 4H-1`; `H >= 2`.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous abort; drops the collection in progress and any pending result.
- `in_valid`  in  1  term present.
- `in_ready`  out  1  block can accept a term.
- `in_tag`  in  2  term id: 0 = low (offset 0), 1 = middle (offset H), 2 = high (offset 2H), 3 = illegal.
- `in_data`  in  TW  partial product, GF(2) coefficients, bit 0 = x^0.
- `out_valid`  out  1  recombined product present.
- `out_ready`  in  1  downstream accepts product.
- `out_data`  out  OW  recombined product.
- `tag_err`  out  1  one-cycle pulse: rejected term (duplicate tag in current collection, or tag 3).

## Operation
- State: `acc[OW-1:0]`, `seen[2:0]` (one bit per tag), `out_valid` flag. Two phases: COLLECT (`out_valid=0`), HOLD (`out_valid=1`).
- `in_ready = !out_valid && !clr`. A term transfers when `in_valid && in_ready`.
- On transfer with legal, unseen tag t: `acc <= acc ^ (in_data << t*H)`; `seen[t] <= 1`.
- On transfer with tag 3, or with `seen[t]` already set: term discarded, `acc`/`seen` unchanged, `tag_err` = 1 next cycle.
- When a transfer makes `seen == 3'b111`: next cycle `out_valid=1`, `out_data = acc` (the register itself drives the output), enter HOLD.
- HOLD: `out_data` stable until `out_valid && out_ready`; on that cycle `acc <= 0`, `seen <= 0`, `out_valid <= 0`, back to COLLECT. No term accepted during HOLD, including the handshake cycle.
- Overlap arithmetic is pure XOR (carry-free); term order does not affect result.
- `clr` (priority over everything except `rst_n`): `acc <= 0`, `seen <= 0`, `out_valid <= 0`, `tag_err <= 0`; a term offered in the same cycle is not accepted (`in_ready=0`).
- Bits of `acc` above `2H+TW-1` never exist: top term ends exactly at bit `OW-1`.

## Timing
- Reset values: `acc=0`, `seen=0`, `out_valid=0`, `tag_err=0`; hence `out_data=0`, `in_ready=1`.
- Latency: `out_valid` rises the cycle after the third legal term transfers.
- Best-case throughput: one product per 4 cycles (3 transfers + 1 output handshake with `out_ready` held high).
- `tag_err` is registered, high exactly one cycle per rejected transfer.
- `rst_n` assertion mid-collection or mid-HOLD clears all state immediately (asynchronous); the pending result is lost.

## Configuration
- `KARA_MIDFIX_EN` defined: middle input is the raw product `(aL^aH)(bL^bH)`; the block also XORs every accepted low and high term additionally at offset H, so the middle contribution becomes `mid ^ low ^ high` at offset H. Extra XOR per accepted low/high term, no extra latency.
- Not defined: middle input is already corrected; each term is added at its own offset only.

## Test plan
- Reset, H=12: `rst_n` low -> `out_valid=0`, `in_ready=1`, `out_data=47'h0`, `tag_err=0`.
- No macro; low=mid=high=23'h000001, tags 0,1,2 back-to-back -> cycle after third transfer `out_valid=1`, `out_data=47'h000001001001`.
- No macro; low=23'h7FFFFF, mid=23'h7FFFFF, high=0, order 2,1,0 -> `out_data=47'h0007FF800FFF` (bits 12..22 cancel).
- Duplicate/illegal: tag 0, tag 0, tag 3, tag 1, tag 2 (all data 1) -> `tag_err` pulses twice, result 47'h000001001001; `out_ready=0` for 5 cycles -> `out_data` stable, `in_ready=0`.
- `clr` after two terms, same cycle as third term -> third term not accepted, `seen=0`, no `out_valid`; fresh three-term collection then yields correct result.
- With `KARA_MIDFIX_EN`: low=23'h1, mid=0, high=0 -> `out_data=47'h1001`; without it -> `47'h1`.
